// File: rtl/pattern_loader_pkg.sv
// Shared types and constants for the pattern loader: buffer word/address types,
// loader error codes, FSM states and the framing sync byte.
package pattern_loader_pkg;

    localparam int LOADER_DATA_WIDTH = 16;
    localparam int LOADER_ADDR_WIDTH = 12;

    typedef logic [LOADER_DATA_WIDTH-1:0] data_t;
    typedef logic [LOADER_ADDR_WIDTH-1:0] addr_t;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_CHECKSUM = 2'd2
    } loader_err_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } loader_state_t;

    // Width of a counter that must be able to hold the value 'cycles'.
    function automatic int tmo_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pattern_loader_byte_packer.sv
// Packs accepted bytes LSB-first into buffer words and emits a registered
// one-cycle word strobe the cycle after the final lane is accepted.
module pattern_loader_byte_packer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  last_lane_o,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_valid_o
);

    localparam int LANES  = DATA_WIDTH / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [LANE_W-1:0]     lane_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_d;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  word_valid_q;

    assign last_lane_o = (lane_q == LAST_LANE);

    // The incoming byte overrides exactly one lane; the rest keep what was collected.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign asm_d[8*gi +: 8] = (lane_q == LANE_W'(gi)) ? byte_i : asm_q[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lane_q       <= '0;
            asm_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                lane_q <= '0;
            end else if (byte_valid_i) begin
                asm_q <= asm_d;
                if (last_lane_o) begin
                    lane_q       <= '0;
                    word_q       <= asm_d;
                    word_valid_q <= 1'b1;
                end else begin
                    lane_q <= lane_q + LANE_W'(1);
                end
            end
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/pattern_loader.sv
// Receives a framed byte stream (sync, payload, XOR checksum) and writes a full
// board image into the double buffer's logic write port while busy.
module pattern_loader
    import pattern_loader_pkg::*;
#(
    parameter int         DATA_WIDTH     = $bits(data_t),
    parameter int         ADDR_WIDTH     = $bits(addr_t),
    parameter int         NUM_WORDS      = 1024,
    parameter logic [7:0] SYNC_BYTE      = LOADER_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid_in,
    output logic                  byte_ready_out,
    output logic [ADDR_WIDTH-1:0] addr_w_out,
    output logic [DATA_WIDTH-1:0] data_w_out,
    output logic                  wr_en_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  err_out,
    output logic [1:0]            err_code_out
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_SAT   = TMO_W'(TIMEOUT_CYCLES);

    loader_state_t         state_q;
    loader_err_t           err_code_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      word_cnt_q;
    logic [7:0]            cks_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [TMO_W-1:0]      tmo_d;

    logic                  hs;
    logic                  sync_hit;
    logic                  data_hs;
    logic                  last_lane;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;

    assign hs       = byte_valid_in && ready_q;
    assign sync_hit = hs && (state_q == ST_SYNC) && (byte_in == SYNC_BYTE);
    assign data_hs  = hs && (state_q == ST_DATA);
    assign tmo_d    = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);

    pattern_loader_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .clear_i      (sync_hit),
        .byte_valid_i (data_hs),
        .byte_i       (byte_in),
        .last_lane_o  (last_lane),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            cks_q      <= '0;
            tmo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == ST_IDLE) begin
                // A start coinciding with the completion pulse belongs to the old frame.
                if (start_in && !done_q && !err_q) begin
                    state_q    <= ST_SYNC;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b1;
                    err_code_q <= ERR_NONE;
                    tmo_q      <= '0;
                end
            end else if (!hs && (tmo_q == TMO_LAST)) begin
                state_q    <= ST_IDLE;
                ready_q    <= 1'b0;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
            end else begin
                tmo_q <= hs ? '0 : tmo_d;
                case (state_q)
                    ST_SYNC: begin
                        if (sync_hit) begin
                            state_q    <= ST_DATA;
                            word_cnt_q <= '0;
                            cks_q      <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (hs) begin
                            cks_q <= cks_q ^ byte_in;
                            if (last_lane) begin
                                addr_q     <= word_cnt_q[ADDR_WIDTH-1:0];
                                word_cnt_q <= word_cnt_q + CNT_W'(1);
                                // The final write lands in the first CHECK cycle, never overlapping done/err.
                                if (word_cnt_q == LAST_WORD) begin
                                    state_q <= ST_CHECK;
                                end
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (hs) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            if (byte_in == cks_q) begin
                                done_q <= 1'b1;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_CHECKSUM;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign byte_ready_out = ready_q;
    assign addr_w_out     = addr_q;
    assign data_w_out     = word;
    assign wr_en_out      = word_valid;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign err_out        = err_q;
    assign err_code_out   = err_code_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Scoreboard bench for pattern_loader with a 4-word board and a short timeout.
module tb_pattern_loader;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int NW = 4;
    localparam int TO = 50;

    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] data_w;
    logic          wr_en;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    pattern_loader #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_WORDS      (NW),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .start_in       (start),
        .byte_in        (byte_data),
        .byte_valid_in  (byte_valid),
        .byte_ready_out (byte_ready),
        .addr_w_out     (addr_w),
        .data_w_out     (data_w),
        .wr_en_out      (wr_en),
        .busy_out       (busy),
        .done_out       (done),
        .err_out        (err),
        .err_code_out   (err_code)
    );

    typedef struct {
        int kind;
        int a;
        int d;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   errors = 0;
    int   checks = 0;
    time  hs_time = 0;

    logic [15:0] exp_words [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    logic [7:0]  payload   [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind, input int a, input int d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected event per observed strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((int'(wr_en) + int'(done) + int'(err)) > 1) begin
                check("strobe_exclusive", int'(wr_en) + int'(done) + int'(err), 1);
            end
            if (wr_en) begin
                $display("write addr=%0d data=0x%04h", addr_w, data_w);
                if (exp_q.size() == 0) begin
                    check("write_expected", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_kind", K_WR, mon_e.kind);
                    check("write_addr", int'(addr_w), mon_e.a);
                    check("write_data", int'(data_w), mon_e.d);
                    check("write_latency", int'($time - hs_time), 5);
                end
            end
            if (done) begin
                $display("done");
                if (exp_q.size() == 0) begin
                    check("done_expected", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_kind", K_DONE, mon_e.kind);
                end
            end
            if (err) begin
                $display("err code=%0d", err_code);
                if (exp_q.size() == 0) begin
                    check("err_expected", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err_kind", K_ERR, mon_e.kind);
                    check("err_code", int'(err_code), mon_e.a);
                end
            end
        end
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit r;
        bit got;
        got = 1'b0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk);
            if (r) begin
                hs_time = $time;
                got     = 1'b1;
                break;
            end
        end
        if (!got) check("byte_accepted", 0, 1);
        #1;
    endtask

    task automatic arm();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("events_drained", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    function automatic int rgap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
    endfunction

    task automatic run_frame(input logic [7:0] cks, input int maxgap, input bit mid_start);
        for (int k = 0; k < NW; k++) push(K_WR, k, int'(exp_words[k]));
        if (cks == 8'h08) push(K_DONE, 0, 0);
        else              push(K_ERR, 2, 0);
        arm();
        send_byte(8'h11, rgap(maxgap));
        send_byte(8'hA5, rgap(maxgap));
        if (mid_start) begin
            byte_valid = 1'b0;
            arm();
        end
        for (int i = 0; i < 8; i++) send_byte(payload[i], rgap(maxgap));
        send_byte(cks, rgap(maxgap));
        byte_valid = 1'b0;
        wait_drain();
        check("busy_after_frame", int'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_seen;
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(byte_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_addr", int'(addr_w), 0);
        check("rst_data", int'(data_w), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stream without arming: nothing may be accepted or written.
        ready_seen = 0;
        for (int i = 0; i < 10; i++) begin
            byte_valid = 1'b1;
            byte_data  = (i == 0) ? 8'hA5 : 8'(i);
            @(negedge clk);
            if (byte_ready) ready_seen++;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        check("ready_without_start", ready_seen, 0);
        check("busy_without_start", int'(busy), 0);

        // Good frame at full throughput.
        run_frame(8'h08, 0, 1'b0);
        check("good_err_code", int'(err_code), 0);

        // Bad checksum.
        run_frame(8'h09, 0, 1'b0);
        check("bad_err_code_held", int'(err_code), 2);

        // Timeout after payload byte 3.
        push(K_WR, 0, 16'h0201);
        push(K_ERR, 1, 0);
        arm();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        byte_valid = 1'b0;
        wait_drain();
        check("timeout_err_code", int'(err_code), 1);
        check("timeout_busy", int'(busy), 0);
        check("timeout_ready", int'(byte_ready), 0);

        // Random valid gaps, with a start pulse while busy that must be ignored.
        run_frame(8'h08, 10, 1'b1);
        check("gap_err_code", int'(err_code), 0);

        // Async reset while a write is on the port.
        arm();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        check("wr_before_reset", int'(wr_en), 1);
        byte_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("wr_after_async_reset", int'(wr_en), 0);
        check("busy_after_async_reset", int'(busy), 0);
        check("ready_after_async_reset", int'(byte_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(8'h08, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
